// File: rtl/mips_lsu.sv
// Load/store unit between the MIPS datapath and a word-addressed data memory.
// Sub-word stores are done as read-modify-write; responses carry extended load data or an error.
module mips_lsu #(
    parameter logic [31:0] DATA_START = 32'h10000000,
    parameter logic [31:0] DATA_BYTES = 32'h00100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
    typedef enum logic [2:0] {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW} op_t;

    state_t      state, state_nx;
    op_t         op_q;
    logic [31:0] addr_q, wdata_q, rdata_q, merged_q;
    logic        err_q;

    logic        misaligned, out_of_range, req_err, is_load;
    logic [32:0] seg_end;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data, merged_word;

    // Range end is computed one bit wider so a segment touching 2^32 cannot wrap.
    assign seg_end      = {1'b0, DATA_START} + {1'b0, DATA_BYTES};
    assign out_of_range = (req_addr < DATA_START) || ({1'b0, req_addr} >= seg_end);
    assign req_err      = misaligned || out_of_range;
    assign is_load      = op_q inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};

    always_comb begin
        misaligned = 1'b0;
        case (op_t'(req_op))
            OP_LH, OP_LHU, OP_SH: misaligned = req_addr[0];
            OP_LW, OP_SW:         misaligned = |req_addr[1:0];
            default:              misaligned = 1'b0;
        endcase
    end

    always_comb begin
        lane_b      = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h      = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        load_data   = '0;
        merged_word = mem_rdata;
        case (op_q)
            OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_data = {24'b0, lane_b};
            OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_data = {16'b0, lane_h};
            OP_LW:   load_data = mem_rdata;
            OP_SB:   merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            OP_SH:   merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: load_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= OP_LB;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            merged_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q    <= op_t'(req_op);
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    if (is_load) rdata_q <= load_data;
                    merged_q <= merged_word;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_addr = {addr_q[31:2], 2'b00};
                if (op_q == OP_SW) begin
                    mem_write = 1'b1;
                    mem_wdata = wdata_q;
                    state_nx  = RESP;
                end else begin
                    mem_read = 1'b1;
                    state_nx = is_load ? RESP : WRITE;
                end
            end
            WRITE: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_write = 1'b1;
                mem_wdata = merged_q;
                state_nx  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Gating here keeps an in-flight write from landing on the reset edge.
        if (reset) begin
            state_nx   = IDLE;
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_rdata = '0;
            resp_err   = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
        end
    end

endmodule
